// File: rtl/lsu_align.sv
// lsu_align: turns byte-addressed B/H/W loads and stores into word-aligned memory transactions with byte strobes.
// Latency: aligned access responds 2 cycles after acceptance (zero-wait memory); a split adds one cycle; rejects respond next cycle.
// Backpressure: req_ready only while idle; all mem_* outputs are held stable while mem_valid=1 and mem_ready=0.
// Build option: define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses in two; otherwise they are rejected with resp_err.
module lsu_align #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1 = 2'd2,
`endif
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              cross_q, cross_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       wdata_hi_q, wdata_hi_d;
    logic [3:0]        wstrb_hi_q, wstrb_hi_d;
`endif

    // Request decode: byte offset, access size, legality and store lane placement.
    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic [3:0]  st_mask;
    logic [31:0] st_data_m;
    logic        req_cross;
    logic        f3_bad;
    logic [31:0] st_data_lo;
    logic [3:0]  st_strb_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [63:0] st_data64;
    logic [7:0]  st_strb8;
`endif

    // Decode the incoming request and place store data/strobes into byte lanes.
    always_comb begin
        req_off = req_addr[1:0];
        case (req_funct3[1:0])
            2'b00: begin
                req_size  = 3'd1;
                st_mask   = 4'b0001;
                st_data_m = {24'b0, req_wdata[7:0]};
            end
            2'b01: begin
                req_size  = 3'd2;
                st_mask   = 4'b0011;
                st_data_m = {16'b0, req_wdata[15:0]};
            end
            default: begin
                req_size  = 3'd4;
                st_mask   = 4'b1111;
                st_data_m = req_wdata;
            end
        endcase
        req_cross = ({1'b0, req_off} + req_size) > 3'd4;
        // Stores have no unsigned variants; loads lack 011 and 11x.
        if (req_we) begin
            f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            f3_bad = (req_funct3 == 3'b011) || (req_funct3[2] && req_funct3[1]);
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        st_data64  = {32'b0, st_data_m} << {req_off, 3'b000};
        st_strb8   = {4'b0, st_mask} << req_off;
        st_data_lo = st_data64[31:0];
        st_strb_lo = st_strb8[3:0];
`else
        st_data_lo = st_data_m << {req_off, 3'b000};
        st_strb_lo = st_mask << req_off;
`endif
    end

    // Truncate a right-justified load word to the access size and extend it.
    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   ld_ext = f3[2] ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   ld_ext = f3[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: ld_ext = w;
        endcase
    endfunction

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        off_d        = off_q;
        f3_d         = f3_q;
        we_d         = we_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        cross_d      = cross_q;
        lo_d         = lo_q;
        wdata_hi_d   = wdata_hi_q;
        wstrb_hi_d   = wstrb_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d = req_off;
                    f3_d  = req_funct3;
                    we_d  = req_we;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    cross_d    = req_cross;
                    wdata_hi_d = req_we ? st_data64[63:32] : 32'b0;
                    wstrb_hi_d = req_we ? st_strb8[7:4] : 4'b0;
                    if (f3_bad) begin
`else
                    if (f3_bad || req_cross) begin
`endif
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACC0;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = req_we ? st_strb_lo : 4'b0;
                        mem_wdata_d = req_we ? st_data_lo : 32'b0;
                    end
                end
            end
            ACC0: begin
                if (mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    lo_d = mem_rdata;
                    if (cross_q) begin
                        // Second word: next address (wraps at the top of memory), upper lanes.
                        state_d     = ACC1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_wstrb_d = wstrb_hi_q;
                        mem_wdata_d = wdata_hi_q;
                    end else
`endif
                    begin
                        state_d      = RESP;
                        mem_valid_d  = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = '0;
                        mem_wstrb_d  = 4'b0;
                        mem_wdata_d  = 32'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? 32'b0 : ld_ext(mem_rdata >> {off_q, 3'b000}, f3_q);
                    end
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ACC1: begin
                if (mem_ready) begin
                    state_d      = RESP;
                    mem_valid_d  = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wstrb_d  = 4'b0;
                    mem_wdata_d  = 32'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'b0
                                 : ld_ext(32'({mem_rdata, lo_q} >> {off_q, 3'b000}), f3_q);
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0;
            mem_wdata_q  <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
            off_q        <= 2'b0;
            f3_q         <= 3'b0;
            we_q         <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            cross_q      <= 1'b0;
            lo_q         <= 32'b0;
            wdata_hi_q   <= 32'b0;
            wstrb_hi_q   <= 4'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            cross_q      <= cross_d;
            lo_q         <= lo_d;
            wdata_hi_q   <= wdata_hi_d;
            wstrb_hi_q   <= wstrb_hi_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed vector table plus reset/wait-state sequences for lsu_align.
// Latency: n/a (bench).
// Backpressure: memory model inserts per-vector wait states and raises stray mem_ready while idle.
module tb_lsu_align;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    lsu_align #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } tx_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] m0;
        logic [31:0] m1;
        int          wt;
        logic        err;
        logic [31:0] rdata;
        int          ntx;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   mem_wait = 0;
    int   hold_viol = 0;
    tx_t  txq[$];
    logic [31:0] mem_words [logic [31:0]];
    vec_t vecs[$];

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wdata, input logic [31:0] m0, input logic [31:0] m1,
                                input int wt, input logic err, input logic [31:0] rdata, input int ntx,
                                input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1);
        vec_t v;
        v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata; v.m0 = m0; v.m1 = m1;
        v.wt = wt; v.err = err; v.rdata = rdata; v.ntx = ntx;
        v.a0 = a0; v.s0 = s0; v.d0 = d0; v.a1 = a1; v.s1 = s1; v.d1 = d1;
        return v;
    endfunction

    // Memory model: wait states per transaction, hold-stability tracking, stray ready while idle.
    initial begin : responder
        tx_t  cap;
        tx_t  cur;
        int   wcnt;
        logic busy;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        busy = 1'b0;
        wcnt = 0;
        cap  = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) busy = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 32'hDEADBEEF;
            cur = {mem_addr, mem_we, mem_wstrb, mem_wdata};
            if (mem_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = 0;
                    cap  = cur;
                end else if (cur !== cap) begin
                    hold_viol++;
                end
                if (wcnt >= mem_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_words.exists(mem_addr) ? mem_words[mem_addr] : 32'h0;
                    txq.push_back(cur);
                end else begin
                    wcnt++;
                end
            end else begin
                busy = 1'b0;
                mem_ready = 1'b1;
            end
        end
    end

    task automatic apply(input vec_t v, input string nm);
        int lat;
        int guard;
        int exp_lat;
        mem_words[{v.addr[31:2], 2'b00}] = v.m0;
        mem_words[{v.addr[31:2], 2'b00} + 32'd4] = v.m1;
        mem_wait = v.wt;
        txq.delete();
        hold_viol = 0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk(nm, "req_ready_before", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 100);
        exp_lat = v.err ? 1 : 1 + v.ntx * (1 + v.wt);
        chk(nm, "resp_latency", lat, exp_lat);
        chk(nm, "resp_err", {31'b0, resp_err}, {31'b0, v.err});
        chk(nm, "resp_rdata", resp_rdata, v.rdata);
        chk(nm, "num_tx", txq.size(), v.ntx);
        if (v.ntx >= 1 && txq.size() >= 1) begin
            chk(nm, "tx0_addr", txq[0].addr, v.a0);
            chk(nm, "tx0_we", {31'b0, txq[0].we}, {31'b0, v.we});
            chk(nm, "tx0_strb", {28'b0, txq[0].strb}, {28'b0, v.s0});
            if (v.we) chk(nm, "tx0_wdata", txq[0].wdata, v.d0);
        end
        if (v.ntx >= 2 && txq.size() >= 2) begin
            chk(nm, "tx1_addr", txq[1].addr, v.a1);
            chk(nm, "tx1_we", {31'b0, txq[1].we}, {31'b0, v.we});
            chk(nm, "tx1_strb", {28'b0, txq[1].strb}, {28'b0, v.s1});
            if (v.we) chk(nm, "tx1_wdata", txq[1].wdata, v.d1);
        end
        chk(nm, "hold_violations", hold_viol, 0);
        @(negedge clk);
        chk(nm, "resp_pulse_end", {31'b0, resp_valid}, 32'd0);
        chk(nm, "req_ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, "mem_valid", {31'b0, mem_valid}, 32'd0);
        chk(nm, "mem_we", {31'b0, mem_we}, 32'd0);
        chk(nm, "mem_addr", mem_addr, 32'd0);
        chk(nm, "mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk(nm, "mem_wdata", mem_wdata, 32'd0);
        chk(nm, "resp_valid", {31'b0, resp_valid}, 32'd0);
        chk(nm, "resp_rdata", resp_rdata, 32'd0);
        chk(nm, "resp_err", {31'b0, resp_err}, 32'd0);
        chk(nm, "req_ready", {31'b0, req_ready}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int guard;
        int n_resp;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_funct3 = 3'b0; req_wdata = 32'h0;

        //                we    addr          f3      wdata         m0            m1            wt err rdata        ntx a0            s0       d0            a1            s1       d1
        vecs.push_back(mk(1'b0, 32'h0000_0103, 3'b000, 32'h0,        32'h80AABBCC, 32'h0,        0, 0, 32'hFFFFFF80, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0103, 3'b100, 32'h0,        32'h80AABBCC, 32'h0,        0, 0, 32'h00000080, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0102, 3'b001, 32'h1234ABCD, 32'h0,        32'h0,        3, 0, 32'h0,        1, 32'h0000_0100, 4'b1100, 32'hABCD0000, 32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0100, 3'b011, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0102, 3'b001, 32'h0,        32'h80AABBCC, 32'h0,        0, 0, 32'hFFFF80AA, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0100, 3'b101, 32'h0,        32'h80AABBCC, 32'h0,        0, 0, 32'h0000BBCC, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0101, 3'b001, 32'h0,        32'h80AABBCC, 32'h0,        0, 0, 32'hFFFFAABB, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0200, 3'b010, 32'h0,        32'h12345678, 32'h0,        0, 0, 32'h12345678, 1, 32'h0000_0200, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0201, 3'b000, 32'hFFFFFF5A, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_0200, 4'b0010, 32'h00005A00, 32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0204, 3'b010, 32'hCAFEF00D, 32'h0,        32'h0,        2, 0, 32'h0,        1, 32'h0000_0204, 4'b1111, 32'hCAFEF00D, 32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0200, 3'b100, 32'h11223344, 32'h0,        32'h0,        0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0200, 3'b111, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0200, 3'b110, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0200, 3'b011, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_00FD, 3'b100, 32'h0,        32'h44332211, 32'h0,        2, 0, 32'h00000022, 1, 32'h0000_00FC, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
`ifdef LSU_MISALIGNED_SPLIT_EN
        vecs.push_back(mk(1'b0, 32'h0000_00FE, 3'b010, 32'h0,        32'h44332211, 32'h88776655, 0, 0, 32'h66554433, 2, 32'h0000_00FC, 4'b0000, 32'h0,        32'h0000_0100, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFD, 3'b010, 32'hDDCCBBAA, 32'h0,        32'h0,        0, 0, 32'h0,        2, 32'hFFFF_FFFC, 4'b1110, 32'hCCBBAA00, 32'h0000_0000, 4'b0001, 32'h000000DD));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, 3'b010, 32'hDDCCBBAA, 32'h0,        32'h0,        0, 0, 32'h0,        2, 32'hFFFF_FFFC, 4'b1000, 32'hAA000000, 32'h0000_0000, 4'b0111, 32'h00DDCCBB));
        vecs.push_back(mk(1'b0, 32'h0000_01FF, 3'b001, 32'h0,        32'h7F000000, 32'h000000FE, 0, 0, 32'hFFFFFE7F, 2, 32'h0000_01FC, 4'b0000, 32'h0,        32'h0000_0200, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0303, 3'b001, 32'h0000BEEF, 32'h0,        32'h0,        1, 0, 32'h0,        2, 32'h0000_0300, 4'b1000, 32'hEF000000, 32'h0000_0304, 4'b0001, 32'h000000BE));
`else
        vecs.push_back(mk(1'b0, 32'h0000_00FE, 3'b010, 32'h0,        32'h44332211, 32'h88776655, 0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFD, 3'b010, 32'hDDCCBBAA, 32'h0,        32'h0,        0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_01FF, 3'b001, 32'h0,        32'h7F000000, 32'h000000FE, 0, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0303, 3'b001, 32'h0000BEEF, 32'h0,        32'h0,        1, 1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0));
`endif

        // Reset state: every output low, including req_ready.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", "req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while the memory is stalling the (last) transaction of a load.
        mem_wait = 20;
        txq.delete();
        mem_words[32'h0FC] = 32'h44332211;
        mem_words[32'h100] = 32'h88776655;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_wdata = 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_addr = 32'h0000_00FE;
`else
        req_addr = 32'h0000_0100;
`endif
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(mem_valid && mem_addr == 32'h100) && guard < 100);
        chk("rst_mid", "stalled_on_0x100", {31'b0, mem_valid && mem_addr == 32'h100}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("rst_mid");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid", "req_ready_after", {31'b0, req_ready}, 32'd1);
        chk("rst_mid", "mem_valid_after", {31'b0, mem_valid}, 32'd0);
        n_resp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        chk("rst_mid", "stray_resp_count", n_resp, 0);

        // Unit recovers after the abandoned access.
        apply(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
